// File: rtl/ble_phy_pkg.sv
// Shared BLE PHY definitions: encoder FSM states, repetition factor and
// default header buffer depth.
package ble_phy_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_SEND = 2'd3
  } state_e;

  localparam int BLE_REP_FACTOR = 3;
  localparam int BLE_HDR_DEPTH  = 64;

endpackage

// File: rtl/repetition_code_encoder_ble_if.sv
// Bit-serial handshake between the header source, the repetition encoder
// and the downstream mapper.
interface repetition_code_encoder_ble_if;

  logic valid_in;
  logic data_in;
  logic enable;
  logic valid_out;
  logic data_out;
  logic finished;
  logic overflow;

  // Source/mapper side: drives bits and the grant, observes the coded stream.
  modport master (
    output valid_in, data_in, enable,
    input  valid_out, data_out, finished, overflow
  );

  // Encoder side.
  modport slave (
    input  valid_in, data_in, enable,
    output valid_out, data_out, finished, overflow
  );

endinterface

// File: rtl/rep_bit_buffer_ble.sv
// DEPTH x 1 header bit store: synchronous write, asynchronous read.
module rep_bit_buffer_ble #(
  parameter int DEPTH = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic                     wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic                     rdata
);

  logic mem [DEPTH];

  // Store the incoming header bit on the edge it is sampled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/repetition_code_encoder_ble.sv
// Rate-1/3 repetition encoder: buffers one burst of header bits, then emits
// each bit three times while the downstream mapper grants enable.
module repetition_code_encoder_ble
  import ble_phy_pkg::*;
#(
  parameter int DEPTH = BLE_HDR_DEPTH
) (
  input logic                          clk,
  input logic                          reset,
  repetition_code_encoder_ble_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] IDLE = ST_IDLE;
  localparam logic [1:0] LOAD = ST_LOAD;
  localparam logic [1:0] WAIT = ST_WAIT;
  localparam logic [1:0] SEND = ST_SEND;

  // Slot index of the final copy of a bit.
  localparam logic [1:0] REP_LAST = 2'(BLE_REP_FACTOR - 1);

  logic [1:0]    state;
  logic [CW-1:0] count;
  logic [AW-1:0] rd_ptr;
  logic [1:0]    rep;

  logic          we;
  logic [AW-1:0] waddr;
  logic [AW-1:0] raddr;
  logic          rdata;
  logic          has_room;
  logic          last_bit;

  assign has_room = (count < CW'(DEPTH));
  // rd_ptr points at the bit currently on data_out.
  assign last_bit = (CW'(rd_ptr) == (count - CW'(1)));

  // Buffer write port: first bit of a burst lands at 0, later ones at count.
  always_comb begin
    we    = 1'b0;
    waddr = {AW{1'b0}};
    if (state == IDLE) begin
      we    = bus.valid_in;
      waddr = {AW{1'b0}};
    end else if (state == LOAD) begin
      we    = bus.valid_in & has_room;
      waddr = count[AW-1:0];
    end else begin
      we    = 1'b0;
      waddr = {AW{1'b0}};
    end
  end

  // Read port looks one bit ahead while sending; bit 0 is fetched from WAIT.
  // The look-ahead past the last bit is never loaded into data_out.
  always_comb begin
    raddr = {AW{1'b0}};
    if (state == SEND) begin
      raddr = rd_ptr + AW'(1);
    end else begin
      raddr = {AW{1'b0}};
    end
  end

  rep_bit_buffer_ble #(
    .DEPTH(DEPTH)
  ) u_buf (
    .clk  (clk),
    .we   (we),
    .waddr(waddr),
    .wdata(bus.data_in),
    .raddr(raddr),
    .rdata(rdata)
  );

  // Burst capture / grant wait / triple-emission state machine and outputs.
  // In SEND each granted edge moves to the next slot; an ungranted edge only
  // drops valid_out, so the stream resumes exactly where it stalled.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      count         <= {CW{1'b0}};
      rd_ptr        <= {AW{1'b0}};
      rep           <= 2'd0;
      bus.valid_out <= 1'b0;
      bus.data_out  <= 1'b0;
      bus.finished  <= 1'b1;
      bus.overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_in) begin
            count        <= CW'(1);
            bus.finished <= 1'b0;
            bus.overflow <= 1'b0;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (bus.valid_in) begin
            if (has_room) begin
              count <= count + CW'(1);
            end else begin
              bus.overflow <= 1'b1;
            end
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (bus.enable) begin
            state         <= SEND;
            bus.data_out  <= rdata;
            bus.valid_out <= 1'b1;
            rep           <= 2'd0;
            rd_ptr        <= {AW{1'b0}};
          end
        end
        SEND: begin
          if (!bus.enable) begin
            bus.valid_out <= 1'b0;
          end else if (rep != REP_LAST) begin
            rep           <= rep + 2'd1;
            bus.valid_out <= 1'b1;
          end else if (last_bit) begin
            bus.valid_out <= 1'b0;
            bus.finished  <= 1'b1;
            state         <= IDLE;
          end else begin
            rep           <= 2'd0;
            rd_ptr        <= rd_ptr + AW'(1);
            bus.data_out  <= rdata;
            bus.valid_out <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_repetition_code_encoder_ble.sv
// Directed self-checking bench for repetition_code_encoder_ble (DEPTH = 8).
module tb_repetition_code_encoder_ble;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   errors = 0;

  logic [63:0] stream;
  int          nv;
  int          first_lat;
  int          gaps;
  int          stall_bad;
  bit          fin_ok;
  bit          done;
  logic        fin_first;
  int          hold_valid;

  repetition_code_encoder_ble_if bus ();

  repetition_code_encoder_ble #(
    .DEPTH(DEPTH)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  // Advance one clock and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Each header bit repeated three times, first bit at stream index 0.
  function automatic logic [63:0] expand3(input logic [15:0] bits, input int n);
    logic [63:0] r;
    r = 64'd0;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 3; k++) begin
        r[3*i+k] = bits[i];
      end
    end
    return r;
  endfunction

  // Drive n contiguous valid bits (LSB first); report finished after the first.
  task automatic send_burst(input logic [15:0] bits, input int n, output logic fin1);
    fin1 = 1'b1;
    for (int i = 0; i < n; i++) begin
      bus.valid_in = 1'b1;
      bus.data_in  = bits[i];
      tick();
      if (i == 0) fin1 = bus.finished;
    end
    bus.valid_in = 1'b0;
    bus.data_in  = 1'b0;
  endtask

  // Record the coded stream until finished rises or the cycle budget runs out.
  // Optionally withdraws enable for stall_len cycles after stall_at valid
  // slots, and optionally toggles valid_in while output is in progress.
  task automatic collect(input int max_cyc, input int stall_at, input int stall_len,
                         input bit noise);
    int  sa;
    bit  prev_v;
    sa        = stall_at;
    prev_v    = 1'b0;
    stream    = 64'd0;
    nv        = 0;
    first_lat = -1;
    gaps      = 0;
    stall_bad = 0;
    fin_ok    = 1'b0;
    done      = 1'b0;
    for (int c = 1; c <= max_cyc && !done; c++) begin
      tick();
      if (bus.finished) begin
        done   = 1'b1;
        fin_ok = prev_v && !bus.valid_out;
      end else begin
        if (bus.valid_out) begin
          if (first_lat < 0) first_lat = c;
          if (nv < 64) stream[nv] = bus.data_out;
          nv++;
        end else if (nv > 0) begin
          gaps++;
        end
        prev_v = bus.valid_out;
        if (noise && nv > 0) begin
          bus.valid_in = nv[0];
          bus.data_in  = ~bus.data_in;
        end
        if (nv == sa) begin
          sa = -1;
          bus.enable = 1'b0;
          for (int s = 0; s < stall_len; s++) begin
            tick();
            if (bus.valid_out !== 1'b0) stall_bad++;
          end
          bus.enable = 1'b1;
          prev_v = 1'b0;
        end
      end
    end
    bus.valid_in = 1'b0;
    bus.data_in  = 1'b0;
  endtask

  initial begin
    bus.valid_in = 1'b0;
    bus.data_in  = 1'b0;
    bus.enable   = 1'b0;
    reset        = 1'b1;
    tick();
    tick();
    chk("rst_valid_out", 64'(bus.valid_out), 64'd0);
    chk("rst_data_out", 64'(bus.data_out), 64'd0);
    chk("rst_finished", 64'(bus.finished), 64'd1);
    chk("rst_overflow", 64'(bus.overflow), 64'd0);
    reset = 1'b0;

    // Burst 1,0,1,1 with enable held high.
    bus.enable = 1'b1;
    send_burst(16'h000D, 4, fin_first);
    chk("t1_fin_low_first", 64'(fin_first), 64'd0);
    collect(200, -1, 0, 1'b0);
    chk("t1_done", 64'(done), 64'd1);
    chk("t1_count", 64'(nv), 64'd12);
    chk("t1_stream", stream, 64'h0FC7);
    chk("t1_latency", 64'(first_lat), 64'd2);
    chk("t1_gaps", 64'(gaps), 64'd0);
    chk("t1_fin_edge", 64'(fin_ok), 64'd1);

    // 5-bit burst, enable low for 10 cycles, then granted.
    bus.enable = 1'b0;
    send_burst(16'h0016, 5, fin_first);
    hold_valid = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.valid_out !== 1'b0) hold_valid++;
    end
    chk("t2_hold_valid", 64'(hold_valid), 64'd0);
    chk("t2_hold_fin", 64'(bus.finished), 64'd0);
    bus.enable = 1'b1;
    collect(200, -1, 0, 1'b0);
    chk("t2_done", 64'(done), 64'd1);
    chk("t2_latency", 64'(first_lat), 64'd1);
    chk("t2_count", 64'(nv), 64'd15);
    chk("t2_stream", stream, 64'h71F8);
    chk("t2_gaps", 64'(gaps), 64'd0);

    // Enable withdrawn for 3 cycles after the 2nd copy of bit 1.
    send_burst(16'h0005, 3, fin_first);
    collect(200, 5, 3, 1'b0);
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_stall_valid", 64'(stall_bad), 64'd0);
    chk("t3_count", 64'(nv), 64'd9);
    chk("t3_stream", stream, 64'h01C7);
    chk("t3_gaps", 64'(gaps), 64'd0);

    // DEPTH+3 bits: trailing ones are dropped and flag overflow.
    send_burst(16'h0796, DEPTH + 3, fin_first);
    chk("t4_overflow", 64'(bus.overflow), 64'd1);
    collect(300, -1, 0, 1'b0);
    chk("t4_done", 64'(done), 64'd1);
    chk("t4_count", 64'(nv), 64'(3 * DEPTH));
    chk("t4_stream", stream, expand3(16'h0096, DEPTH));
    chk("t4_overflow_sticky", 64'(bus.overflow), 64'd1);

    // New burst clears overflow; valid_in pulses during output are ignored.
    send_burst(16'h0001, 2, fin_first);
    chk("t5_overflow_clr", 64'(bus.overflow), 64'd0);
    collect(200, -1, 0, 1'b1);
    chk("t5_done", 64'(done), 64'd1);
    chk("t5_count", 64'(nv), 64'd6);
    chk("t5_stream", stream, 64'h0007);
    chk("t5_overflow", 64'(bus.overflow), 64'd0);

    // Back-to-back overflowing burst, then reset in the middle of SEND.
    send_burst(16'h0335, 10, fin_first);
    chk("t6_fin_low_first", 64'(fin_first), 64'd0);
    chk("t6_overflow", 64'(bus.overflow), 64'd1);
    tick();
    tick();
    tick();
    chk("t6_in_send", 64'(bus.valid_out), 64'd1);
    reset = 1'b1;
    tick();
    chk("t6_rst_valid", 64'(bus.valid_out), 64'd0);
    chk("t6_rst_fin", 64'(bus.finished), 64'd1);
    chk("t6_rst_ovf", 64'(bus.overflow), 64'd0);
    reset = 1'b0;
    send_burst(16'h0002, 2, fin_first);
    collect(200, -1, 0, 1'b0);
    chk("t6_done", 64'(done), 64'd1);
    chk("t6_count", 64'(nv), 64'd6);
    chk("t6_stream", stream, 64'h0038);
    chk("t6_fin_edge", 64'(fin_ok), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/repetition_code_encoder_ble.md
# repetition_code_encoder_ble

Rate-1/3 repetition encoder for the BLE PHY transmit header path. It collects a burst of header bits into an internal 1-bit buffer, then, once the downstream mapper grants `enable`, it emits every stored bit three times in consecutive valid cycles. The output stream `b0 b0 b0 b1 b1 b1 …` is exactly the framing consumed by the receive-side repetition decoder's majority vote.

## Interface
- `DEPTH`, default 64: maximum header bits buffered per burst; must be ≥ 2.
- `clk` input 1: single clock; all logic is on the rising edge.
- `reset` input 1: synchronous, active-high reset.
- `valid_in` input 1: qualifies `data_in`; a burst is one contiguous run of `valid_in`=1.
- `data_in` input 1: header bit, LSB-first order preserved.
- `enable` input 1: downstream grant; must be high for output to advance.
- `valid_out` output 1: qualifies `data_out`; registered.
- `data_out` output 1: repeated coded bit; registered.
- `finished` output 1: high when idle or done; low from the first accepted bit through the last output bit.
- `overflow` output 1: sticky for the current burst; set when bits beyond `DEPTH` are dropped.

## Operation
- Reset and interface decision: one clock; reset is synchronous and active-high.
- Reset values: `valid_out`=0, `data_out`=0, `finished`=1, `overflow`=0, state IDLE, all pointers and counters 0.
- State machine with four states: IDLE, LOAD, WAIT, SEND.
- **IDLE**
  - `valid_in`=1: write bit at address 0, set `count`=1, `finished`<=0, `overflow`<=0, go to LOAD.
- **LOAD**
  - `valid_in`=1 and `count`<`DEPTH`: write at address `count`, then `count`++.
  - `valid_in`=1 and `count`=`DEPTH`: drop the bit and set `overflow`<=1.
  - `valid_in`=0: go to WAIT.
- **WAIT**
  - `enable`=1: go to SEND, load `data_out`<=buf[0], `valid_out`<=1, `rep`=0, `rd_ptr`=0.
  - `enable`=0: hold.
- **SEND** (`rep` counts 0,1,2)
  - Each cycle with `enable`=1 advances one output slot.
  - At `rep`=2, `rd_ptr` increments and `rep` wraps to 0.
  - The slot after the third copy of bit `count`-1 does not exist: on that edge `valid_out`<=0, `finished`<=1, go to IDLE.
  - `enable`=0 in SEND: `valid_out`<=0; `rep`, `rd_ptr` and `data_out` hold. When `enable` returns, the stream resumes at the same bit and repetition, with no slot lost or duplicated.
- `valid_in` in WAIT or SEND is ignored. The buffer is not overwritten, and no new burst starts until IDLE.
- Total output per burst is exactly 3×min(N, `DEPTH`) valid cycles.
- Widths:
  - `count`: $clog2(`DEPTH`+1).
  - `rd_ptr`: $clog2(`DEPTH`).
  - `rep`: 2 bits; value 3 is unreachable.
- `reset` in any state returns all outputs to their reset values on the next edge and discards buffered data.

## Timing
- Write latency: the bit is stored on the same edge `valid_in` is sampled.
- Start latency: `enable` sampled high in WAIT at edge t gives the first `valid_out`=1 in the cycle after t.
- A burst ending at edge t (last `valid_in`=1 sampled) puts the block in WAIT after t+1. If `enable` is already high, the first output is visible 2 cycles after the last input.
- `finished` rises on the same edge that `valid_out` falls after the final slot.
- A new burst may start on the edge immediately after `finished` rises.
- With `enable` held high, throughput is one output bit per cycle, with no gaps between repetitions or between bits.

## Structure
- Shared package `ble_phy_pkg` holds:
  - the state enum (IDLE/LOAD/WAIT/SEND);
  - `BLE_REP_FACTOR`=3;
  - default header depth 64.
- Sub-module `rep_bit_buffer_ble`: `DEPTH`×1 register array with synchronous write and asynchronous read. The top level registers its read output into `data_out`.
- The top level contains the FSM, `count`, `rd_ptr` and `rep` counters, and the output registers.

## Test plan
- Reset, then burst 1,0,1,1 with `enable` held high → `data_out` = 111 000 111 111 over 12 contiguous `valid_out` cycles; `finished` low from the first input, high with the final `valid_out` fall.
- Burst of 5 bits with `enable` low for 10 cycles → block holds in WAIT with `valid_out`=0; after `enable` rises, first output appears 1 cycle later and 15 valid slots follow.
- `enable` dropped after the 2nd copy of bit 1 for 3 cycles → `valid_out`=0 during the gap; output resumes with the 3rd copy of bit 1; total valid slots still equal 3N.
- Burst of `DEPTH`+3 bits → `overflow`=1; exactly 3×`DEPTH` valid outputs; dropped bits never appear.
- `valid_in` pulsed during SEND → output unchanged; after `finished`, the next burst encodes correctly and `overflow` is cleared.
- `reset` asserted mid-SEND → next edge shows `valid_out`=0, `finished`=1, `overflow`=0; a following 2-bit burst gives 6 correct outputs.
